// File: rtl/cereal_pkg.sv
// Shared definitions for the cereal serial link: frame width, default bit
// timing and the receiver FSM encoding, so transmitter and receiver agree.
package cereal_pkg;

   localparam int DATA_BITS            = 8;
   localparam int CLKS_PER_BIT_DEFAULT = 434;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/cereal_rx_if.sv
// Bundle between a cereal line driver and the receiver: the serial line in,
// and the received byte with its status strobes out.
interface cereal_rx_if;
   import cereal_pkg::*;

   logic                 cereal;
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 frame_err;
   logic                 busy;

   modport master (output cereal, input data, valid, frame_err, busy);
   modport slave  (input cereal, output data, valid, frame_err, busy);

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to
// RESET_VAL so an idle line does not look like an edge after reset.
module sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic sysclk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_reg;
   logic q_reg;

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         meta_reg <= RESET_VAL;
         q_reg    <= RESET_VAL;
      end else begin
         meta_reg <= d;
         q_reg    <= meta_reg;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/cereal_rx.sv
// Cereal UART-style receiver: 8N1 frames, LSB first, mid-bit sampling on the
// synchronized line, one-cycle valid / frame_err strobes.
module cereal_rx
   import cereal_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input logic        sysclk,
   input logic        reset,
   cereal_rx_if.slave rx
);

   localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

   if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
      $error("cereal_rx: CLKS_PER_BIT must be at least 4");
   end

   logic                 rx_s;
   logic                 rx_prev_reg;
   rx_state_t            state_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic [2:0]           bit_idx_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic [DATA_BITS-1:0] data_reg;
   logic                 valid_reg;
   logic                 frame_err_reg;
   logic                 busy_reg;

   sync2 #(.RESET_VAL(1'b1)) u_sync (
      .sysclk (sysclk),
      .reset  (reset),
      .d      (rx.cereal),
      .q      (rx_s)
   );

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         rx_prev_reg   <= 1'b1;
         cnt_reg       <= '0;
         bit_idx_reg   <= '0;
         shift_reg     <= '0;
         data_reg      <= '0;
         valid_reg     <= 1'b0;
         frame_err_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         valid_reg     <= 1'b0;
         frame_err_reg <= 1'b0;
         rx_prev_reg   <= rx_s;

         case (state_reg)
            IDLE: begin
               // Only a 1->0 transition starts a frame; a stuck-low line never does.
               if (rx_prev_reg && !rx_s) begin
                  state_reg <= START;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b1;
               end
            end

            START: begin
               if (cnt_reg == HALF_LAST) begin
                  cnt_reg <= '0;
                  if (!rx_s) begin
                     state_reg   <= DATA;
                     bit_idx_reg <= '0;
                  end else begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            DATA: begin
               if (cnt_reg == FULL_LAST) begin
                  cnt_reg   <= '0;
                  shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                  if (bit_idx_reg == LAST_BIT) begin
                     state_reg <= STOP;
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            STOP: begin
               if (cnt_reg == FULL_LAST) begin
                  cnt_reg   <= '0;
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  if (rx_s) begin
                     data_reg  <= shift_reg;
                     valid_reg <= 1'b1;
                  end else begin
                     frame_err_reg <= 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign rx.data      = data_reg;
   assign rx.valid     = valid_reg;
   assign rx.frame_err = frame_err_reg;
   assign rx.busy      = busy_reg;

endmodule

// File: tb/tb_cereal_rx.sv
// Directed bench for cereal_rx at 16 clocks per bit: framing, timing, glitch
// rejection, stop-bit errors, mid-frame reset and a 256-byte sweep.
module tb_cereal_rx;
   import cereal_pkg::*;

   localparam int CPB = 16;

   logic sysclk = 1'b0;
   logic reset  = 1'b1;

   cereal_rx_if bus ();

   cereal_rx #(.CLKS_PER_BIT(CPB)) dut (
      .sysclk (sysclk),
      .reset  (reset),
      .rx     (bus)
   );

   always #5 sysclk = ~sysclk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge sysclk) cyc <= cyc + 1;

   // Monitor: log every strobe with its cycle, plus pulse-shape statistics.
   int         vq_cyc[$];
   logic [7:0] vq_data[$];
   int         ferr_cnt  = 0;
   int         run       = 0;
   int         max_run   = 0;
   int         both      = 0;
   int         busy_rise = -1;
   int         busy_fall = -1;
   logic       busy_d    = 1'b0;

   always @(negedge sysclk) begin
      if (bus.valid) begin
         vq_cyc.push_back(cyc);
         vq_data.push_back(bus.data);
      end
      if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
      if (bus.valid && bus.frame_err) both <= both + 1;
      if (bus.valid || bus.frame_err) begin
         run <= run + 1;
         if (run + 1 > max_run) max_run <= run + 1;
      end else begin
         run <= 0;
      end
      busy_d <= bus.busy;
      if (bus.busy && !busy_d) busy_rise <= cyc;
      if (!bus.busy && busy_d) busy_fall <= cyc;
   end

   task automatic send_frame(input logic [7:0] b, input logic stop);
      bus.cereal = 1'b0;
      repeat (CPB) @(negedge sysclk);
      for (int i = 0; i < 8; i++) begin
         bus.cereal = b[i];
         repeat (CPB) @(negedge sysclk);
      end
      bus.cereal = stop;
      repeat (CPB) @(negedge sysclk);
   endtask

   task automatic idle(input int n);
      bus.cereal = 1'b1;
      repeat (n) @(negedge sysclk);
   endtask

   task automatic test_reset();
      checks++;
      if (bus.data !== 8'h00) begin
         errors++; $display("FAIL reset_data: got %h expected 00", bus.data);
      end
      checks++;
      if (bus.valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid);
      end
      checks++;
      if (bus.frame_err !== 1'b0) begin
         errors++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
      end
   endtask

   task automatic test_single();
      int base = vq_cyc.size();
      int t    = cyc;
      send_frame(8'hA5, 1'b1);
      idle(4);
      checks++;
      if (vq_cyc.size() - base != 1) begin
         errors++; $display("FAIL single_count: got %0d expected 1", vq_cyc.size() - base);
      end else begin
         checks++;
         if (vq_data[base] !== 8'hA5) begin
            errors++; $display("FAIL single_data: got %h expected a5", vq_data[base]);
         end
         checks++;
         if (vq_cyc[base] < t + 154 || vq_cyc[base] > t + 156) begin
            errors++; $display("FAIL single_latency: got %0d expected 155 (+/-1)", vq_cyc[base] - t);
         end
         checks++;
         if (busy_fall !== vq_cyc[base]) begin
            errors++; $display("FAIL single_busy_fall: got %0d expected %0d", busy_fall - t, vq_cyc[base] - t);
         end
      end
      checks++;
      if (busy_rise < t + 2 || busy_rise > t + 4) begin
         errors++; $display("FAIL single_busy_rise: got %0d expected 3 (+/-1)", busy_rise - t);
      end
      checks++;
      if (max_run !== 1) begin
         errors++; $display("FAIL single_pulse_width: got %0d expected 1", max_run);
      end
      checks++;
      if (bus.data !== 8'hA5 || bus.valid !== 1'b0) begin
         errors++; $display("FAIL single_hold: got data %h valid %b expected a5 0", bus.data, bus.valid);
      end
   endtask

   task automatic test_back_to_back();
      int base = vq_cyc.size();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(4);
      checks++;
      if (vq_cyc.size() - base != 2) begin
         errors++; $display("FAIL b2b_count: got %0d expected 2", vq_cyc.size() - base);
      end else begin
         checks++;
         if (vq_data[base] !== 8'h00 || vq_data[base+1] !== 8'hFF) begin
            errors++; $display("FAIL b2b_data: got %h %h expected 00 ff", vq_data[base], vq_data[base+1]);
         end
         checks++;
         if (vq_cyc[base+1] - vq_cyc[base] != 160) begin
            errors++; $display("FAIL b2b_spacing: got %0d expected 160", vq_cyc[base+1] - vq_cyc[base]);
         end
      end
   endtask

   task automatic test_glitch();
      int base = vq_cyc.size();
      int fb   = ferr_cnt;
      bus.cereal = 1'b0;
      repeat (3) @(negedge sysclk);
      bus.cereal = 1'b1;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++; $display("FAIL glitch_busy_start: got %b expected 1", bus.busy);
      end
      repeat (9) @(negedge sysclk);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL glitch_busy_end: got %b expected 0", bus.busy);
      end
      idle(10);
      checks++;
      if (vq_cyc.size() != base || ferr_cnt != fb) begin
         errors++; $display("FAIL glitch_no_pulse: got %0d valid %0d frame_err expected 0 0",
                            vq_cyc.size() - base, ferr_cnt - fb);
      end
      send_frame(8'h3C, 1'b1);
      idle(4);
      checks++;
      if (vq_cyc.size() - base != 1 || bus.data !== 8'h3C) begin
         errors++; $display("FAIL glitch_next_frame: got count %0d data %h expected 1 3c",
                            vq_cyc.size() - base, bus.data);
      end
   endtask

   task automatic test_frame_err();
      int base = vq_cyc.size();
      int fb   = ferr_cnt;
      send_frame(8'h5A, 1'b1);
      send_frame(8'h81, 1'b0);
      idle(20);
      checks++;
      if (ferr_cnt - fb != 1) begin
         errors++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - fb);
      end
      checks++;
      if (vq_cyc.size() - base != 1) begin
         errors++; $display("FAIL ferr_valid_count: got %0d expected 1", vq_cyc.size() - base);
      end
      checks++;
      if (bus.data !== 8'h5A) begin
         errors++; $display("FAIL ferr_data_hold: got %h expected 5a", bus.data);
      end
      send_frame(8'h33, 1'b1);
      idle(4);
      checks++;
      if (vq_cyc.size() - base != 2 || bus.data !== 8'h33) begin
         errors++; $display("FAIL ferr_recover: got count %0d data %h expected 2 33",
                            vq_cyc.size() - base, bus.data);
      end
   endtask

   task automatic test_reset_midframe();
      int base = vq_cyc.size();
      int fb   = ferr_cnt;
      fork
         send_frame(8'hC3, 1'b1);
         begin
            repeat (CPB * 4 + 8) @(negedge sysclk);
            checks++;
            if (bus.busy !== 1'b1) begin
               errors++; $display("FAIL midrst_busy_before: got %b expected 1", bus.busy);
            end
            reset = 1'b1;
            #1;
            checks++;
            if (bus.data !== 8'h00 || bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.frame_err !== 1'b0) begin
               errors++; $display("FAIL midrst_outputs: got data %h busy %b valid %b frame_err %b expected 00 0 0 0",
                                  bus.data, bus.busy, bus.valid, bus.frame_err);
            end
         end
      join
      @(negedge sysclk);
      reset = 1'b0;
      idle(10);
      checks++;
      if (vq_cyc.size() != base || ferr_cnt != fb) begin
         errors++; $display("FAIL midrst_no_pulse: got %0d valid %0d frame_err expected 0 0",
                            vq_cyc.size() - base, ferr_cnt - fb);
      end
      send_frame(8'h96, 1'b1);
      idle(4);
      checks++;
      if (vq_cyc.size() - base != 1 || bus.data !== 8'h96) begin
         errors++; $display("FAIL midrst_next_frame: got count %0d data %h expected 1 96",
                            vq_cyc.size() - base, bus.data);
      end
   endtask

   task automatic test_loopback();
      int base = vq_cyc.size();
      int fb   = ferr_cnt;
      for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1);
      idle(4);
      checks++;
      if (vq_cyc.size() - base != 256) begin
         errors++; $display("FAIL loop_count: got %0d expected 256", vq_cyc.size() - base);
      end else begin
         for (int i = 0; i < 256; i++) begin
            checks++;
            if (vq_data[base+i] !== 8'(i)) begin
               errors++; $display("FAIL loop_data[%0d]: got %h expected %h", i, vq_data[base+i], 8'(i));
            end
         end
      end
      checks++;
      if (ferr_cnt != fb) begin
         errors++; $display("FAIL loop_frame_err: got %0d expected 0", ferr_cnt - fb);
      end
      checks++;
      if (max_run !== 1 || both !== 0) begin
         errors++; $display("FAIL pulse_shape: got max width %0d overlaps %0d expected 1 0", max_run, both);
      end
   endtask

   initial begin
      bus.cereal = 1'b1;
      reset      = 1'b1;
      repeat (3) @(negedge sysclk);
      test_reset();
      reset = 1'b0;
      idle(5);
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_midframe();
      test_loopback();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cereal_rx.md
CEREAL_RX -- requirements
Module: cereal_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, sysclk cycles per serial bit; SHALL be at least 4.
REQ-002 sysclk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 cereal  input  1  asynchronous serial line from a cereal transmitter; idles high.
REQ-005 data  output  8  last correctly framed byte received.
REQ-006 valid  output  1  one-cycle pulse; data updated in the same cycle.
REQ-007 frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-008 busy  output  1  high in every state except IDLE.

Function
REQ-009 Frame format SHALL be: start bit low, 8 data bits LSB first, one stop bit high, each CLKS_PER_BIT cycles long.
REQ-010 cereal SHALL pass through a two-flop synchronizer reset to 1; all logic below uses the synchronized line (rx_s).
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-012 IDLE: rx_s falling edge (previous 1, current 0) -> START with bit counter cleared; a line held low produces no new edge.
REQ-013 START: at counter == CLKS_PER_BIT/2 - 1 (integer division), sample rx_s; low -> DATA, counter cleared; high -> IDLE with no outputs (glitch reject).
REQ-014 DATA: at counter == CLKS_PER_BIT - 1, shift sampled rx_s into bit 7 of the shift register (LSB first) and clear the counter; after the 8th sample -> STOP.
REQ-015 STOP: at counter == CLKS_PER_BIT - 1, sample rx_s. High: load data from the shift register, pulse valid. Low: pulse frame_err, data unchanged. Both cases -> IDLE.
REQ-016 valid and frame_err SHALL never assert together and SHALL never be high longer than one cycle.
REQ-017 Sample points SHALL fall CLKS_PER_BIT/2 + k*CLKS_PER_BIT cycles (k = 0..9) after the synchronized falling edge; the valid/frame_err pulse comes one cycle after the k = 9 sample.
REQ-018 A new start edge arriving in the IDLE cycle immediately after a completed frame SHALL be accepted (back-to-back frames, no gap required).
REQ-019 Counter width SHALL be $clog2(CLKS_PER_BIT); the counter never exceeds CLKS_PER_BIT - 1.
REQ-020 The bit index SHALL be 3 bits and count 0..7; it is cleared on entry to DATA.

Reset
REQ-021 Reset values: state IDLE, data 8'h00, valid 0, frame_err 0, busy 0, shift register 0, counters 0, synchronizer flops 1.
REQ-022 Reset asserted mid-frame SHALL abandon the frame with no valid or frame_err pulse; after release, the next falling edge starts a clean frame.

Structure
REQ-023 Shared package cereal_pkg SHALL hold the FSM state encodings, DATA_BITS = 8, and the default CLKS_PER_BIT; cereal and cereal_rx both use it so that bit timing matches.
REQ-024 One sub-module, sync2 (two-flop synchronizer, reset value parameterized), SHALL be instantiated for cereal.
REQ-025 cereal_rx SHALL contain no other sub-modules and no combinational path from cereal to any output.

Verification (CLKS_PER_BIT = 16)
REQ-026 Send 0xA5 framed, raw falling edge at cycle t -> data = 0xA5 and valid high for exactly one cycle at t + 155 (±1); busy high from about t + 3 until the pulse.
REQ-027 Send 0x00 then 0xFF back-to-back with no idle gap -> two valid pulses 160 cycles apart; data reads 0x00 then 0xFF.
REQ-028 Drive cereal low for 3 cycles, then high -> no valid and no frame_err; busy returns low by cycle 12; a following frame 0x3C is received correctly.
REQ-029 After receiving 0x5A, send 0x81 with the stop bit low -> frame_err pulses once, valid stays 0, data remains 0x5A; a subsequent good frame is received.
REQ-030 Assert reset during the 4th data bit of 0xC3 -> all outputs go to reset values immediately with no pulse; after release, frame 0x96 yields data = 0x96.
REQ-031 Loopback: connect cereal.cereal to cereal_rx.cereal and send 256 sequential bytes -> 256 valid pulses, each data equal to the sent byte, zero frame_err.
